// File: rtl/serial_pkg.sv
// Shared types and constants for the host serial link (transmitter now, receiver later).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int CLK_PER_BIT_DEF = 50;
  localparam int FRAME_BITS      = 10;
  // 8N1: everything in the frame except the start and stop bits is payload
  localparam int DATA_W          = FRAME_BITS - 2;
  localparam int BIT_IDX_W       = $clog2(DATA_W);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter with a one-byte holding register and a synchronized host-side hold input.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_data,
  input  logic [DATA_W-1:0] data,
  input  logic              block,
  output logic              tx,
  output logic              tx_block,
  output logic              dropped
);

  localparam int                   CNT_W    = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_W - 1);

  tx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]  bit_q, bit_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
  logic                  dropped_q, dropped_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     hold_q, hold_d;

  logic block_s;
  logic accept;
  logic bit_end;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_block_sync (
    .clk (clk),
    .rst (rst),
    .d_i (block),
    .q_o (block_s)
  );

  // Flow control is an OR of flops only, so new_data never feeds back into tx_block
  assign tx_block = hold_full_q | block_s;
  assign accept   = new_data & ~tx_block;
  assign bit_end  = (cnt_q == CNT_LAST);

  // State register: control flops carry the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      dropped_q   <= dropped_d;
    end
  end

  // Byte storage is qualified by state/hold_full, so it needs no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  // Next-state: FSM, bit-time counter, bit index, shifter and holding register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        // accept already implies hold is empty and block_s is low
        if (accept) begin
          shift_d = data;
          cnt_d   = '0;
          state_d = START;
        end else if (hold_full_q && !block_s) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_IDX_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (hold_full_q && !block_s) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // While a frame is running the accepted byte waits in hold; never collides
    // with the hold-to-shifter move because accept needs hold empty
    if (accept && (state_q != IDLE)) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
  end

  // Output: the line is registered from the next state so the start bit lands one cycle after accept
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    dropped_d = new_data & tx_block;
  end

  assign tx      = tx_q;
  assign dropped = dropped_q;

endmodule

// File: doc/serial_tx.md
# serial_tx

UART transmitter that drains the byte stream produced by the BDM host interface and drives the host serial line. It accepts one byte per `new_data` strobe, frames it as 8N1 (start, 8 data LSB-first, 1 stop), and exposes `tx_block` back to the interface as the only flow-control signal. A one-byte holding register gives gap-free back-to-back frames. An external `block` input (host-side bridge not ready) pauses frame starts.

## Interface
- `CLK_PER_BIT`, default 50: clock cycles per serial bit; must be ≥ 2.
- `clk  in  1`: sole clock.
- `rst  in  1`: asynchronous, active-high reset.
- `new_data  in  1`: byte strobe; honoured only when `tx_block` is low in the same cycle.
- `data  in  8`: byte to send, sampled with `new_data`.
- `block  in  1`: asynchronous host-side hold request.
- `tx  out  1`: serial line, idle high.
- `tx_block  out  1`: high means `new_data` this cycle will be ignored.
- `dropped  out  1`: one-cycle pulse when `new_data` arrives while `tx_block` is high.

## Operation
- `block` passes through a 2-FF synchronizer (`block_s`). Both flops reset to 1.
- `tx_block = hold_full | block_s`. This is an OR of registers only; there is no combinational path from `new_data`.
- Accept (`new_data & !tx_block`):
  - If the FSM is IDLE and `block_s` is 0, the byte loads the shifter directly and the FSM goes to START.
  - Otherwise the byte loads the holding register and `hold_full` is set.
- FSM states:
  - IDLE: `tx=1`. Leaves when a byte is loaded.
  - START: `tx=0` for `CLK_PER_BIT` cycles, then DATA.
  - DATA: `tx=shift[0]`. Shift right every `CLK_PER_BIT` cycles. After bit 7 (3-bit counter reaches 7 and wraps), go to STOP.
  - STOP: `tx=1` for `CLK_PER_BIT` cycles. At the end:
    - if `hold_full & !block_s`: move hold to shifter, clear `hold_full`, go to START;
    - else go to IDLE.
- `block_s` never aborts a frame in progress. It only stops START entry from IDLE/STOP, and it forces `tx_block` high.
- When IDLE with `hold_full` set and `block_s` falling, the held byte starts the next cycle.
- Bit counter width is `$clog2(CLK_PER_BIT)`. It counts 0..`CLK_PER_BIT`-1 and wraps, with no drift across frames.
- `dropped` is registered and asserted the cycle after the ignored strobe. The ignored byte is discarded, and hold/shifter are unchanged.

## Timing
- Reset values:
  - `tx=1`, `dropped=0`, `hold_full=0`, FSM=IDLE.
  - `tx_block=1`, because the synchronizer resets to 1. It falls 2 cycles after reset release if `block` is low.
- `tx` is registered. The start bit appears on `tx` 1 cycle after an accepting strobe into an idle shifter.
- Frame length is exactly `10*CLK_PER_BIT` cycles.
- Back-to-back frames (hold full at STOP end) have zero idle cycles between the stop bit and the next start bit.
- `tx_block` rises the cycle after a byte lands in hold. It falls the cycle after hold moves to the shifter.
- Throughput: one byte per `10*CLK_PER_BIT` cycles sustained, and at most 2 bytes buffered (shifter + hold).
- `block` edges reach `tx_block` after 2–3 cycles. Upstream must tolerate one more accepted byte in that window; the hold register absorbs it.
- Reset mid-frame: `tx` returns high asynchronously, and buffered bytes are lost.

## Structure
- Package `serial_pkg` holds:
  - state enum `tx_state_t` {IDLE, START, DATA, STOP};
  - default `CLK_PER_BIT`;
  - constant `FRAME_BITS=10`.
- Sub-module `sync_2ff` (parameterised reset value), shared with the future `serial_rx`.
- Everything else is one always block for the FSM/counters plus the registered outputs.

## Test plan
- `CLK_PER_BIT=4`, send 0x55 from idle → `tx` low at cycle +1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; frame is 40 cycles; `tx_block` stays low.
- Strobe 0xA5 and 0x3C on consecutive cycles → `tx_block` high from cycle +2; 0x3C's start bit immediately follows 0xA5's stop bit; `tx_block` drops when the 0x3C frame starts.
- Third strobe while `tx_block`=1 → `dropped` pulses one cycle; line output is byte-for-byte unchanged.
- Assert `block` mid-frame with hold=0x80 → current frame completes; `tx` idles high; on `block` release 0x80 starts within 3 cycles.
- Assert `rst` during DATA bit 3 → `tx=1` immediately; after release `tx_block`=1 for 2 cycles, then 0; next strobe sends a clean frame.
- Random 1000-byte stream honouring `tx_block`, decoded by a bench UART model → all bytes received in order, none dropped.
